// File: rtl/cfi_pkg.sv
// ============================================================================
// Module      : cfi_pkg
// Description : Shared types and widths for the CFI alert controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cfi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ALERT    = 2'd1,
    ST_HALT_REQ = 2'd2,
    ST_HALTED   = 2'd3
  } state_t;

  localparam int REC_W   = 48;
  localparam int STAMP_W = 16;
  localparam int CNT_W   = 8;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cfi_log_fifo.sv
// ============================================================================
// Module      : cfi_log_fifo
// Description : Show-ahead violation log FIFO; push while full is refused
//               unless a pop happens in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cfi_log_fifo #(
  parameter int DEPTH = 4,
  parameter int REC_W = 48
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [REC_W-1:0] i_data,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic [REC_W-1:0] o_head,
  output logic             o_empty,
  output logic             o_full
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;

  logic [REC_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr;
  logic [PTR_W-1:0] r_rd;
  logic             w_wr;
  logic             w_rd;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign o_empty = (r_wr == r_rd);
  assign o_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_rd    = i_pop & ~o_empty & ~i_flush;
  assign w_wr    = i_push & (~o_full | w_rd) & ~i_flush;
  assign o_head  = r_mem[r_rd[AW-1:0]];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr <= '0;
      r_rd <= '0;
    end else if (i_flush) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_wr) r_wr <= r_wr + 1'b1;
      if (w_rd) r_rd <= r_rd + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wr[AW-1:0]] <= i_data;
  end

endmodule

`default_nettype wire

// File: rtl/cfi_alert_ctrl.sv
// ============================================================================
// Module      : cfi_alert_ctrl
// Description : Turns the decoder violation flag into logging, interrupt,
//               halt handshake and reset escalation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cfi_alert_ctrl
  import cfi_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int HALT_THRESH = 2,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_signal,
  input  logic [31:0]      i_instr_addr,
  input  logic             i_rd_en,
  input  logic             i_clr,
  input  logic             i_halt_ack,
  output logic [REC_W-1:0] o_rd_data,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count,
  output logic             o_overflow,
  output logic             o_irq,
  output logic             o_halt_req,
  output logic             o_rst_req
);

  localparam int                 TMO_W      = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]   c_thresh   = CNT_W'(HALT_THRESH);
  localparam logic [TMO_W-1:0]   c_tmo_last = TMO_W'(ACK_TIMEOUT - 1);

  state_t             r_state;
  logic               r_sig_prev;
  logic [STAMP_W-1:0] r_stamp;
  logic [TMO_W-1:0]   r_tmo;
  logic [CNT_W-1:0]   r_count;
  logic               r_overflow;
  logic               r_irq;
  logic               r_halt_req;
  logic               r_rst_req;

  logic               w_event;
  logic               w_pop;
  logic               w_empty;
  logic               w_full;
  logic [REC_W-1:0]   w_head;
  logic [CNT_W-1:0]   w_count_inc;
  logic               w_escalate;

  // An event landing in the same cycle as a clear is thrown away.
  assign w_event     = i_signal & ~r_sig_prev & ~i_clr;
  assign w_pop       = i_rd_en & ~w_empty;
  assign w_count_inc = sat_inc(r_count);
  assign w_escalate  = (w_count_inc >= c_thresh);

  cfi_log_fifo #(
    .DEPTH (DEPTH),
    .REC_W (REC_W)
  ) u_log_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_event),
    .i_data  ({r_stamp, i_instr_addr}),
    .i_pop   (w_pop),
    .i_flush (i_clr),
    .o_head  (w_head),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sig_prev <= 1'b0;
      r_stamp    <= '0;
    end else begin
      r_sig_prev <= i_signal;
      r_stamp    <= r_stamp + 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (i_clr) begin
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (w_event) begin
      r_count <= w_count_inc;
      if (w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_tmo      <= '0;
      r_irq      <= 1'b0;
      r_halt_req <= 1'b0;
      r_rst_req  <= 1'b0;
    end else begin
      r_rst_req <= 1'b0;
      if (i_clr) begin
        r_state    <= ST_IDLE;
        r_tmo      <= '0;
        r_irq      <= 1'b0;
        r_halt_req <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE, ST_ALERT: begin
            if (w_event) begin
              r_irq <= 1'b1;
              if (w_escalate) begin
                r_state    <= ST_HALT_REQ;
                r_halt_req <= 1'b1;
                r_tmo      <= '0;
              end else begin
                r_state <= ST_ALERT;
              end
            end
          end
          ST_HALT_REQ: begin
            // Ack takes precedence over a timeout in the same cycle.
            if (i_halt_ack) begin
              r_state    <= ST_HALTED;
              r_halt_req <= 1'b0;
            end else if (r_tmo == c_tmo_last) begin
              r_state    <= ST_HALTED;
              r_halt_req <= 1'b0;
              r_rst_req  <= 1'b1;
            end else begin
              r_tmo <= r_tmo + 1'b1;
            end
          end
          ST_HALTED: begin
            r_state <= ST_HALTED;
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign o_rd_data  = w_empty ? '0 : w_head;
  assign o_empty    = w_empty;
  assign o_count    = r_count;
  assign o_overflow = r_overflow;
  assign o_irq      = r_irq;
  assign o_halt_req = r_halt_req;
  assign o_rst_req  = r_rst_req;

endmodule

`default_nettype wire

// File: tb/tb_cfi_alert_ctrl.sv
// ============================================================================
// Module      : tb_cfi_alert_ctrl
// Description : Directed self-checking bench for cfi_alert_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cfi_alert_ctrl;
  import cfi_pkg::*;

  localparam int DEPTH       = 4;
  localparam int HALT_THRESH = 2;
  localparam int ACK_TIMEOUT = 64;

  logic             clk        = 1'b0;
  logic             rst        = 1'b1;
  logic             signal     = 1'b0;
  logic [31:0]      instr_addr = '0;
  logic             rd_en      = 1'b0;
  logic             clr        = 1'b0;
  logic             halt_ack   = 1'b0;
  logic [REC_W-1:0] rd_data;
  logic             empty;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic             irq;
  logic             halt_req;
  logic             rst_req;

  int checks = 0;
  int errors = 0;
  int rst_req_seen = 0;
  logic [15:0] cyc;
  logic [47:0] exp_q [$];

  cfi_alert_ctrl #(
    .DEPTH       (DEPTH),
    .HALT_THRESH (HALT_THRESH),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_signal     (signal),
    .i_instr_addr (instr_addr),
    .i_rd_en      (rd_en),
    .i_clr        (clr),
    .i_halt_ack   (halt_ack),
    .o_rd_data    (rd_data),
    .o_empty      (empty),
    .o_count      (count),
    .o_overflow   (overflow),
    .o_irq        (irq),
    .o_halt_req   (halt_req),
    .o_rst_req    (rst_req)
  );

  always #5 clk = ~clk;

  // Bench copy of the free-running stamp: equals the DUT stamp between edges.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= '0;
    else     cyc <= cyc + 16'd1;
  end

  always @(negedge clk) begin
    if (rst_req) rst_req_seen++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [31:0] pc, output logic [47:0] rec);
    instr_addr = pc;
    signal     = 1'b1;
    rec        = {cyc, pc};
    tick();
    signal = 1'b0;
    tick();
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    logic [47:0] rec;
    logic [47:0] rec0;
    int n;

    // Reset state
    repeat (3) tick();
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_irq", irq, 0);
    check("rst_halt", halt_req, 0);
    check("rst_rstreq", rst_req, 0);
    check("rst_ovf", overflow, 0);
    check("rst_data", rd_data, 0);
    rst = 1'b0;
    tick();

    // Held level counts once
    instr_addr = 32'h0000_045C;
    signal     = 1'b1;
    rec0       = {cyc, 32'h0000_045C};
    tick();
    check("lvl_count1", count, 1);
    check("lvl_irq", irq, 1);
    check("lvl_empty", empty, 0);
    check("lvl_data", rd_data, rec0);
    repeat (9) tick();
    signal = 1'b0;
    tick();
    check("lvl_count_held", count, 1);
    check("lvl_halt", halt_req, 0);
    check("lvl_data_held", rd_data, rec0);

    // Asynchronous reset mid-ALERT
    #2;
    rst = 1'b1;
    #1;
    check("arst_irq", irq, 0);
    check("arst_count", count, 0);
    check("arst_empty", empty, 1);
    check("arst_data", rd_data, 0);
    tick();
    rst = 1'b0;
    tick();

    // Halt handshake with ack after 5 cycles
    rst_req_seen = 0;
    pulse(32'h100, rec);
    instr_addr = 32'h104;
    signal     = 1'b1;
    tick();
    signal = 1'b0;
    check("hs_halt_e0", halt_req, 1);
    for (int k = 1; k < 5; k++) begin
      tick();
      check("hs_halt_hi", halt_req, 1);
    end
    halt_ack = 1'b1;
    tick();
    halt_ack = 1'b0;
    check("hs_halt_lo", halt_req, 0);
    check("hs_irq", irq, 1);
    repeat (70) tick();
    check("hs_no_rstreq", rst_req_seen, 0);
    check("hs_halted_irq", irq, 1);
    check("hs_halted_halt", halt_req, 0);
    check("hs_count", count, 2);
    do_clr();
    check("clr_irq", irq, 0);
    check("clr_count", count, 0);
    check("clr_empty", empty, 1);

    // Ack timeout escalation
    rst_req_seen = 0;
    pulse(32'h200, rec);
    instr_addr = 32'h204;
    signal     = 1'b1;
    tick();
    signal = 1'b0;
    check("to_halt_rise", halt_req, 1);
    n = 0;
    while (!rst_req && n < 200) begin
      tick();
      n++;
    end
    check("to_delay", n, 64);
    check("to_halt_drop", halt_req, 0);
    tick();
    check("to_pulse_end", rst_req, 0);
    check("to_irq", irq, 1);
    check("to_seen_once", rst_req_seen, 1);
    do_clr();

    // Overflow: six pulses into four entries
    exp_q.delete();
    for (int i = 0; i < 6; i++) begin
      pulse(32'h1000 + 32'(4 * i), rec);
      if (i < 4) exp_q.push_back(rec);
    end
    check("of_count", count, 6);
    check("of_flag", overflow, 1);
    for (int i = 0; i < 4; i++) begin
      check("of_rec", rd_data, exp_q[i]);
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
    end
    check("of_empty", empty, 1);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("of_pop_empty", empty, 1);
    do_clr();
    check("of_clr", overflow, 0);

    // Pop and push together while full
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      pulse(32'h3000 + 32'(4 * i), rec);
      exp_q.push_back(rec);
    end
    check("pp_no_ovf_pre", overflow, 0);
    instr_addr = 32'h2000;
    signal     = 1'b1;
    rd_en      = 1'b1;
    rec        = {cyc, 32'h2000};
    tick();
    signal = 1'b0;
    rd_en  = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back(rec);
    check("pp_no_ovf", overflow, 0);
    check("pp_count", count, 5);
    for (int i = 0; i < 4; i++) begin
      check("pp_rec", rd_data, exp_q[i]);
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
    end
    check("pp_empty", empty, 1);
    do_clr();

    // Clear coincident with an event while HALTED
    pulse(32'h300, rec);
    pulse(32'h304, rec);
    halt_ack = 1'b1;
    tick();
    halt_ack = 1'b0;
    check("cc_halted", halt_req, 0);
    check("cc_irq_pre", irq, 1);
    signal = 1'b1;
    clr    = 1'b1;
    tick();
    clr = 1'b0;
    check("cc_count", count, 0);
    check("cc_empty", empty, 1);
    check("cc_irq", irq, 0);
    check("cc_halt", halt_req, 0);
    tick();
    signal = 1'b0;
    tick();
    check("cc_no_event", count, 0);
    check("cc_still_idle", irq, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
